// File: rtl/fpga_config_loader.sv
// Bitstream loader: serialises host words into the CLB or connection scan chain and
// returns the bits shifted out of that chain as readback words.
module fpga_config_loader #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned CLB_CHAIN_LEN  = 64,
    parameter int unsigned CONN_CHAIN_LEN = 256,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  chain_sel,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  clb_scan_in,
    output logic                  clb_scan_en,
    input  logic                  clb_scan_out,
    output logic                  conn_scan_in,
    output logic                  conn_scan_en,
    input  logic                  conn_scan_out,
    output logic [DATA_WIDTH-1:0] rb_data,
    output logic                  rb_valid,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  bit_count
);

    localparam int unsigned IDX_WIDTH = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_WIDTH-1:0] CLB_LEN   = CNT_WIDTH'(CLB_CHAIN_LEN);
    localparam logic [CNT_WIDTH-1:0] CONN_LEN  = CNT_WIDTH'(CONN_CHAIN_LEN);
    localparam logic [IDX_WIDTH-1:0] WORD_LAST = IDX_WIDTH'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

    state_e                  state_q, state_d;
    logic                    sel_q, sel_d;
    logic [CNT_WIDTH-1:0]    len_q, len_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [IDX_WIDTH-1:0]    idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
    logic [DATA_WIDTH-1:0]   asm_q, asm_d;
    logic [DATA_WIDTH-1:0]   rb_data_q, rb_data_d;
    logic                    rb_valid_q, rb_valid_d;

    logic                    scan_bit;
    logic [CNT_WIDTH-1:0]    cnt_inc;
    logic                    last_bit;
    logic                    last_word_bit;

    assign scan_bit      = sel_q ? conn_scan_out : clb_scan_out;
    assign cnt_inc       = cnt_q + 1'b1;
    assign last_bit      = (cnt_inc == len_q);
    assign last_word_bit = (idx_q == WORD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            sel_q      <= 1'b0;
            len_q      <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            shreg_q    <= '0;
            asm_q      <= '0;
            rb_data_q  <= '0;
            rb_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shreg_q    <= shreg_d;
            asm_q      <= asm_d;
            rb_data_q  <= rb_data_d;
            rb_valid_q <= rb_valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        shreg_d      = shreg_q;
        asm_d        = asm_q;
        rb_data_d    = rb_data_q;
        rb_valid_d   = 1'b0;
        in_ready     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        clb_scan_en  = 1'b0;
        clb_scan_in  = 1'b0;
        conn_scan_en = 1'b0;
        conn_scan_in = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    sel_d   = chain_sel;
                    len_d   = chain_sel ? CONN_LEN : CLB_LEN;
                    cnt_d   = '0;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                if (in_valid) begin
                    shreg_d = in_data;
                    idx_d   = '0;
                    asm_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                busy = 1'b1;
                if (sel_q) begin
                    conn_scan_en = 1'b1;
                    conn_scan_in = shreg_q[0];
                end else begin
                    clb_scan_en = 1'b1;
                    clb_scan_in = shreg_q[0];
                end
                shreg_d        = shreg_q >> 1;
                asm_d[idx_q]   = scan_bit;
                cnt_d          = cnt_inc;
                idx_d          = idx_q + 1'b1;
                // A short final word exits early; asm was cleared on accept so
                // its unused upper bits read back as zero.
                if (last_bit || last_word_bit) begin
                    state_d    = last_bit ? StDone : StLoad;
                    rb_data_d  = asm_d;
                    rb_valid_d = 1'b1;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign rb_data   = rb_data_q;
    assign rb_valid  = rb_valid_q;
    assign bit_count = cnt_q;

endmodule

// File: tb/tb_fpga_config_loader.sv
// Scoreboard bench for fpga_config_loader: behavioural scan chains feed readback,
// a forked monitor pops expected readback words and tallies scan/done activity.
module tb_fpga_config_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        chain_sel;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        clb_scan_in, clb_scan_en, clb_scan_out;
    logic        conn_scan_in, conn_scan_en, conn_scan_out;
    logic [7:0]  rb_data;
    logic        rb_valid;
    logic        busy;
    logic        done;
    logic [15:0] bit_count;

    logic [7:0]  clb_chain;
    logic [9:0]  conn_chain;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int clb_en_cnt = 0;
    int conn_en_cnt = 0;
    logic exp_q[$];
    logic [7:0] exp_rb[$];
    logic clb_bits[$];
    logic conn_bits[$];

    always #5 clk = ~clk;

    assign clb_scan_out  = clb_chain[0];
    assign conn_scan_out = conn_chain[0];

    fpga_config_loader #(
        .DATA_WIDTH    (8),
        .CLB_CHAIN_LEN (8),
        .CONN_CHAIN_LEN(10),
        .CNT_WIDTH     (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .chain_sel    (chain_sel),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .clb_scan_in  (clb_scan_in),
        .clb_scan_en  (clb_scan_en),
        .clb_scan_out (clb_scan_out),
        .conn_scan_in (conn_scan_in),
        .conn_scan_en (conn_scan_en),
        .conn_scan_out(conn_scan_out),
        .rb_data      (rb_data),
        .rb_valid     (rb_valid),
        .busy         (busy),
        .done         (done),
        .bit_count    (bit_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Chains shift on the same edge the DUT samples scan_out, hence non-blocking.
    task automatic chain_model();
        forever begin
            @(posedge clk);
            if (clb_scan_en) clb_chain <= {clb_scan_in, clb_chain[7:1]};
            if (conn_scan_en) conn_chain <= {conn_scan_in, conn_chain[9:1]};
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (rb_valid) begin
                    if (exp_rb.size() == 0) check("unexpected rb_valid", {24'd0, rb_data}, 32'hFFFF_FFFF);
                    else check("rb_data", {24'd0, rb_data}, {24'd0, exp_rb.pop_front()});
                end
                if (done) done_cnt++;
                if (clb_scan_en) begin
                    clb_en_cnt++;
                    clb_bits.push_back(clb_scan_in);
                end
                if (conn_scan_en) begin
                    conn_en_cnt++;
                    conn_bits.push_back(conn_scan_in);
                end
            end
        end
    endtask

    task automatic do_start(input logic sel);
        start     = 1'b1;
        chain_sel = sel;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_ready();
        logic got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            if (in_ready) got = 1'b1;
            else tick();
        end
        check("in_ready timeout", {31'd0, got}, 32'd1);
    endtask

    task automatic send_word(input logic [7:0] w, input logic [7:0] exp, input logic push);
        wait_ready();
        if (push) exp_rb.push_back(exp);
        in_valid = 1'b1;
        in_data  = w;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        logic got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            tick();
            if (done) got = 1'b1;
        end
        check("done timeout", {31'd0, got}, 32'd1);
        tick();
    endtask

    function automatic logic [31:0] pack(input logic bits[$]);
        logic [31:0] v = '0;
        for (int i = 0; i < bits.size() && i < 32; i++) v[i] = bits[i];
        return v;
    endfunction

    initial begin
        int clb0, conn0, done0;
        rst_n     = 1'b0;
        start     = 1'b0;
        chain_sel = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        clb_chain  = 8'h3C;
        conn_chain = 10'h2C5;
        fork
            monitor();
            chain_model();
        join_none

        #23;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset in_ready", {31'd0, in_ready}, 32'd0);
        check("reset scan_en", {30'd0, clb_scan_en, conn_scan_en}, 32'd0);
        check("reset rb", {23'd0, rb_valid, rb_data}, 32'd0);
        check("reset bit_count", {16'd0, bit_count}, 32'd0);
        rst_n = 1'b1;
        tick();

        // CLB load of 0xA5 against a chain preloaded with 0x3C
        clb0 = clb_en_cnt; conn0 = conn_en_cnt; done0 = done_cnt;
        clb_bits.delete();
        do_start(1'b0);
        check("busy after start", {31'd0, busy}, 32'd1);
        send_word(8'hA5, 8'h3C, 1'b1);
        wait_done();
        check("A clb_scan_en cycles", clb_en_cnt - clb0, 32'd8);
        check("A conn_scan_en cycles", conn_en_cnt - conn0, 32'd0);
        check("A done pulses", done_cnt - done0, 32'd1);
        check("A bit_count", {16'd0, bit_count}, 32'd8);
        check("A clb_scan_in seq", pack(clb_bits), 32'hA5);
        check("A idle busy", {31'd0, busy}, 32'd0);

        // Readback chain: 0xFF returns 0xA5, then 0x00 returns 0xFF
        do_start(1'b0);
        send_word(8'hFF, 8'hA5, 1'b1);
        wait_done();
        do_start(1'b0);
        send_word(8'h00, 8'hFF, 1'b1);
        wait_done();
        check("C rb_data hold", {24'd0, rb_data}, 32'hFF);

        // Connection chain, partial final word, 5-cycle stall between words
        clb0 = clb_en_cnt; conn0 = conn_en_cnt; done0 = done_cnt;
        conn_bits.delete();
        do_start(1'b1);
        send_word(8'h12, 8'hC5, 1'b1);
        wait_ready();
        for (int i = 0; i < 5; i++) begin
            check("stall in_ready", {31'd0, in_ready}, 32'd1);
            check("stall scan_en", {30'd0, clb_scan_en, conn_scan_en}, 32'd0);
            check("stall bit_count", {16'd0, bit_count}, 32'd8);
            tick();
        end
        send_word(8'hFF, 8'h02, 1'b1);
        wait_done();
        check("D conn_scan_en cycles", conn_en_cnt - conn0, 32'd10);
        check("D clb_scan_en cycles", clb_en_cnt - clb0, 32'd0);
        check("D done pulses", done_cnt - done0, 32'd1);
        check("D bit_count", {16'd0, bit_count}, 32'd10);
        check("D conn_scan_in seq", pack(conn_bits), 32'h312);
        check("D partial rb_data", {24'd0, rb_data}, 32'h02);

        // start with flipped chain_sel during SHIFT must be ignored
        clb0 = clb_en_cnt; conn0 = conn_en_cnt; done0 = done_cnt;
        do_start(1'b1);
        send_word(8'h00, 8'h12, 1'b1);
        start     = 1'b1;
        chain_sel = 1'b0;
        tick();
        start     = 1'b0;
        chain_sel = 1'b1;
        send_word(8'h00, 8'h03, 1'b1);
        wait_done();
        tick(); tick(); tick();
        check("E conn_scan_en cycles", conn_en_cnt - conn0, 32'd10);
        check("E clb_scan_en cycles", clb_en_cnt - clb0, 32'd0);
        check("E done pulses", done_cnt - done0, 32'd1);
        check("E idle after", {30'd0, busy, in_ready}, 32'd0);

        // Async reset mid-SHIFT after three bits, then a full clean reload
        do_start(1'b0);
        send_word(8'h07, 8'h00, 1'b0);
        begin
            logic got = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                if (bit_count == 16'd3) got = 1'b1;
                else tick();
            end
            check("F reach bit 3", {31'd0, got}, 32'd1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("F rst scan_en", {30'd0, clb_scan_en, conn_scan_en}, 32'd0);
        check("F rst busy/in_ready", {30'd0, busy, in_ready}, 32'd0);
        check("F rst rb_valid", {31'd0, rb_valid}, 32'd0);
        check("F rst bit_count", {16'd0, bit_count}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("F idle after reset", {30'd0, busy, done}, 32'd0);
        clb0 = clb_en_cnt; done0 = done_cnt;
        do_start(1'b0);
        send_word(8'h5A, 8'hE0, 1'b1);
        check("F restart bit_count", {16'd0, bit_count}, 32'd0);
        wait_done();
        check("F clb_scan_en cycles", clb_en_cnt - clb0, 32'd8);
        check("F bit_count", {16'd0, bit_count}, 32'd8);
        check("F done pulses", done_cnt - done0, 32'd1);
        check("rb queue drained", exp_rb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpga_config_loader.md
Name: fpga_config_loader

Overview:
- Bitstream loader directly upstream of the 2x2 FPGA fabric top level.
- Accepts configuration words over a valid/ready stream and serialises them into the selected scan chain: CLB chain or connection (SB/CB) chain.
- Drives that chain's scan_in/scan_en one bit per cycle.
- Captures the bits falling out of the chain's scan_out and returns them as readback words, so the host can verify the previous configuration.

Parameters:
- DATA_WIDTH, 8, width of host configuration/readback words.
- CLB_CHAIN_LEN, 64, total bits in CLB scan chain (>=1).
- CONN_CHAIN_LEN, 256, total bits in connection scan chain (>=1).
- CNT_WIDTH, 16, width of bit counter; must hold max(CLB_CHAIN_LEN, CONN_CHAIN_LEN).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a chain load; ignored unless idle.
- chain_sel  input  1  sampled with start: 0 = CLB chain, 1 = connection chain.
- in_data  input  DATA_WIDTH  configuration word; LSB shifted first.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts in_data this cycle.
- clb_scan_in  output  1  serial data to CLB chain.
- clb_scan_en  output  1  CLB chain shift enable.
- clb_scan_out  input  1  serial data returning from CLB chain.
- conn_scan_in  output  1  serial data to connection chain.
- conn_scan_en  output  1  connection chain shift enable.
- conn_scan_out  input  1  serial data returning from connection chain.
- rb_data  output  DATA_WIDTH  readback word.
- rb_valid  output  1  one-cycle pulse, rb_data valid; no backpressure.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse, load complete.
- bit_count  output  CNT_WIDTH  bits shifted so far in the current load.

Behaviour:
- Reset (async, immediate) clears everything: all outputs 0, state IDLE, counters 0. Scan enables drop at once, so a reset mid-load freezes both chains and leaves them partially loaded; no recovery is attempted.
- Target length L = CLB_CHAIN_LEN or CONN_CHAIN_LEN, latched with chain_sel on start.
- State IDLE:
  - busy=0, in_ready=0.
  - start=1: latch sel and L, clear bit_count, go to LOAD.
- State LOAD:
  - in_ready=1, scan_en both 0.
  - in_valid=1: register in_data into shift register, clear word bit index, go to SHIFT.
  - in_valid=0: wait indefinitely; chains hold.
- State SHIFT:
  - Selected chain: scan_en=1, scan_in=shreg[0]. Unselected chain: scan_en=0, scan_in=0.
  - Each cycle: shreg shifts right; the selected scan_out is sampled into rb assembly bit [word bit index]; bit_count and word index increment.
  - Leave SHIFT after the cycle where bit_count reaches L, or the word index reaches DATA_WIDTH, whichever is first.
  - If bit_count==L, go to DONE; otherwise go to LOAD.
  - Only the low (L mod DATA_WIDTH) bits of the final word are shifted when L is not a multiple of DATA_WIDTH; remaining bits are discarded.
- Minimum one LOAD cycle (scan_en low) between words; throughput is DATA_WIDTH bits per DATA_WIDTH+1 cycles with in_valid held.
- Readback:
  - On the cycle after each SHIFT exit, rb_data = assembled word and rb_valid=1 for one cycle.
  - A partial final word is LSB-aligned, with unused upper bits 0.
  - rb_data holds its value until the next readback.
- State DONE: done=1 for one cycle, busy=0, then IDLE. Number of accepted words = ceil(L/DATA_WIDTH).
- start while busy is ignored, with no effect on sel or L.
- in_valid outside LOAD is ignored (in_ready=0).
- bit_count saturates at L; it resets to 0 only on start or reset.

Test Plan:
- CLB_CHAIN_LEN=8, chain_sel=0, start, word 0xA5 with in_valid held → clb_scan_en high exactly 8 consecutive cycles; clb_scan_in sequence 1,0,1,0,0,1,0,1; conn_scan_en stays 0; done pulses once; bit_count=8.
- Readback: model the CLB chain as an 8-bit shift register preloaded 0x3C, load 0xFF → rb_data=0x3C with a one-cycle rb_valid; a second load of 0x00 returns rb_data=0xFF.
- Partial word: CONN_CHAIN_LEN=10, chain_sel=1, words 0x12, 0xFF → exactly 10 conn_scan_en cycles; second word shifts only bits 1,1; second rb_data has bits [7:2]=0; done after 2 words.
- Stall: in_valid low for 5 cycles between words → in_ready high throughout, both scan_en low, bit_count held at 8; resumes correctly when in_valid rises.
- start pulsed during SHIFT with chain_sel flipped → ignored; same chain finishes and done pulses exactly once.
- Reset: assert rst_n=0 mid-SHIFT (bit_count=3) → scan_en, busy, in_ready, rb_valid go 0 asynchronously; after release, IDLE; a new start performs a full load from bit_count=0.
